// File: rtl/step_channel_bank_if.sv
// ---------------------------------------------------------------------------
// step_channel_bank_if
// picorv32 native memory bus, seen from one peripheral.
//   mem_valid_in   CPU request
//   mem_instr_in   instruction-fetch flag
//   mem_addr_in    byte address
//   mem_wdata_in   write data
//   mem_wstrb_in   byte strobes, 0 = read
//   mem_rdata_out  read data, 0 when not ready
//   mem_ready_out  one-cycle acknowledge
// master: the CPU side.  slave: the peripheral side.
// ---------------------------------------------------------------------------
interface step_channel_bank_if;
    logic        mem_valid_in;
    logic        mem_instr_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [3:0]  mem_wstrb_in;
    logic [31:0] mem_rdata_out;
    logic        mem_ready_out;

    modport master (
        output mem_valid_in, mem_instr_in, mem_addr_in, mem_wdata_in, mem_wstrb_in,
        input  mem_rdata_out, mem_ready_out
    );

    modport slave (
        input  mem_valid_in, mem_instr_in, mem_addr_in, mem_wdata_in, mem_wstrb_in,
        output mem_rdata_out, mem_ready_out
    );
endinterface

// File: rtl/step_channel_bank.sv
// ---------------------------------------------------------------------------
// step_channel_bank
// NUM_CH-channel step/dir pulse generator with a memory-mapped register file
// on the picorv32 native bus. Each channel issues a counted burst of
// PULSE_WIDTH-cycle step pulses at a programmable period.
//
// Ports
//   clk_in        peripheral clock
//   reset_n_in    asynchronous active-low reset
//   bus           step_channel_bank_if.slave (CPU memory bus)
//   step_out      step pulses, one per channel
//   dir_out       direction, frozen while a burst runs
//   enable_n_out  active-low driver enable (~CTRL.EN)
//
// Register map per channel (BASE_ADDR + 16*ch):
//   +0 CTRL   b0 START (pulse), b1 DIR, b2 EN, b3 ABORT (pulse)
//   +4 STEPS  steps to issue / remaining
//   +8 DIV    period in clk_in cycles, floored at 2*PULSE_WIDTH
//   +C STATUS b0 BUSY, b1 DONE (sticky), [31:8] position
//
// Build option: define STEP_POSITION_EN to add a signed per-channel step
// position counter, reported in STATUS[31:8].
// ---------------------------------------------------------------------------
module step_channel_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned PULSE_WIDTH = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0040
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    step_channel_bank_if.slave    bus,
    output logic [NUM_CH-1:0]     step_out,
    output logic [NUM_CH-1:0]     dir_out,
    output logic [NUM_CH-1:0]     enable_n_out
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(2 * PULSE_WIDTH);
    localparam logic [DIV_WIDTH-1:0] PW         = DIV_WIDTH'(PULSE_WIDTH);
    localparam logic [31:0]          END_ADDR   = BASE_ADDR + 32'(16 * NUM_CH);

    state_t                state [NUM_CH];
    logic [CNT_WIDTH-1:0]  steps [NUM_CH];
    logic [DIV_WIDTH-1:0]  div   [NUM_CH];
    logic [DIV_WIDTH-1:0]  phase [NUM_CH];
    logic [DIV_WIDTH-1:0]  eff   [NUM_CH];
    logic [NUM_CH-1:0]     ctrl_dir, ctrl_en, done, dir_q;
`ifdef STEP_POSITION_EN
    logic signed [CNT_WIDTH-1:0] pos [NUM_CH];
`endif

    logic [31:0] offset, rd_val, rdata_q;
    logic [3:0]  ch_idx;
    logic [1:0]  reg_idx;
    logic        sel, accept, wr, ready_q;
    logic [NUM_CH-1:0] wr_ctrl, wr_steps, wr_div, start_req, abort_req, dir_next;
    logic        unused_ok;

    // Byte-lane merge of a write into an existing 32-bit register image.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign offset  = bus.mem_addr_in - BASE_ADDR;
    assign ch_idx  = offset[7:4];
    assign reg_idx = offset[3:2];
    assign sel     = bus.mem_valid_in && !bus.mem_instr_in &&
                     (bus.mem_addr_in >= BASE_ADDR) && (bus.mem_addr_in < END_ADDR);
    // A held request is acknowledged every other cycle: ready must drop in between.
    assign accept  = sel && !ready_q;
    assign wr      = accept && (bus.mem_wstrb_in != 4'd0);
    assign unused_ok = ^{offset[31:8], offset[1:0]};

    assign bus.mem_ready_out = ready_q;
    assign bus.mem_rdata_out = rdata_q;
    assign enable_n_out      = ~ctrl_en;
    assign dir_out           = dir_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ctrl  = '0;
        wr_steps = '0;
        wr_div   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr && ch_idx == 4'(c)) begin
                wr_ctrl[c]  = (reg_idx == 2'd0) && bus.mem_wstrb_in[0];
                wr_steps[c] = (reg_idx == 2'd1);
                wr_div[c]   = (reg_idx == 2'd2);
            end
            eff[c] = (div[c] < MIN_PERIOD) ? MIN_PERIOD : div[c];
        end
        // ABORT in the same write suppresses START.
        start_req = wr_ctrl & {NUM_CH{bus.mem_wdata_in[0] & ~bus.mem_wdata_in[3]}};
        abort_req = wr_ctrl & {NUM_CH{bus.mem_wdata_in[3]}};
        // DIR as it will be after this write, so a START+DIR write latches the new direction.
        dir_next  = (wr_ctrl & {NUM_CH{bus.mem_wdata_in[1]}}) | (~wr_ctrl & ctrl_dir);
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
                case (reg_idx)
                    2'd0:    rd_val = {28'd0, 1'b0, ctrl_en[c], ctrl_dir[c], 1'b0};
                    2'd1:    rd_val = 32'(steps[c]);
                    2'd2:    rd_val = 32'(div[c]);
`ifdef STEP_POSITION_EN
                    default: rd_val = {24'(pos[c]), 6'd0, done[c], state[c] == RUN};
`else
                    default: rd_val = {30'd0, done[c], state[c] == RUN};
`endif
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            step_out <= '0;
            dir_q    <= '0;
            ctrl_dir <= '0;
            ctrl_en  <= '0;
            done     <= '0;
            // NOTE: the register arrays are flops that must read 0 after reset, so every entry is reset.
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= IDLE;
                steps[c] <= '0;
                div[c]   <= '0;
                phase[c] <= '0;
`ifdef STEP_POSITION_EN
                pos[c]   <= '0;
`endif
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
            ready_q <= accept;
            rdata_q <= accept ? rd_val : 32'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ctrl[c]) begin
                    ctrl_dir[c] <= bus.mem_wdata_in[1];
                    ctrl_en[c]  <= bus.mem_wdata_in[2];
                end
                case (state[c])
                    IDLE: begin
                        dir_q[c]    <= dir_next[c];
                        step_out[c] <= 1'b0;
                        if (wr_steps[c])
                            steps[c] <= CNT_WIDTH'(merge(32'(steps[c]), bus.mem_wdata_in,
                                                         bus.mem_wstrb_in));
                        if (wr_div[c])
                            div[c] <= DIV_WIDTH'(merge(32'(div[c]), bus.mem_wdata_in,
                                                       bus.mem_wstrb_in));
                        if (start_req[c]) begin
                            if (steps[c] != '0) begin
                                state[c] <= RUN;
                                phase[c] <= '0;
                                done[c]  <= 1'b0;
                            end else begin
                                done[c]  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (abort_req[c]) begin
                            state[c]    <= IDLE;
                            step_out[c] <= 1'b0;
                        end else begin
                            // Pulse occupies phases 0..PW-1 of each period.
                            step_out[c] <= (phase[c] < PW);
`ifdef STEP_POSITION_EN
                            if (phase[c] == '0)
                                pos[c] <= dir_q[c] ? pos[c] + CNT_WIDTH'(1)
                                                   : pos[c] - CNT_WIDTH'(1);
`endif
                            if (phase[c] == eff[c] - DIV_WIDTH'(1)) begin
                                phase[c] <= '0;
                                steps[c] <= steps[c] - CNT_WIDTH'(1);
                                if (steps[c] == CNT_WIDTH'(1)) begin
                                    state[c] <= IDLE;
                                    done[c]  <= 1'b1;
                                end
                            end else begin
                                phase[c] <= phase[c] + DIV_WIDTH'(1);
                            end
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_step_channel_bank.sv
// ---------------------------------------------------------------------------
// tb_step_channel_bank
// Directed self-checking bench for step_channel_bank (default parameters).
// Expected step_out traces are hand-written bit patterns: bit i is the value
// sampled 1 ns after the i-th clock edge following the START acknowledge edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_channel_bank;
    localparam logic [31:0] BASE = 32'h1000_0040;

    logic       clk_in = 1'b0;
    logic       reset_n_in;
    logic [3:0] step_out, dir_out, enable_n_out;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    step_channel_bank_if bus ();

    step_channel_bank dut (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .bus          (bus),
        .step_out     (step_out),
        .dir_out      (dir_out),
        .enable_n_out (enable_n_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    function automatic logic [31:0] reg_addr(input int ch, input int r);
        return BASE + 32'(16 * ch + 4 * r);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] q);
        bit got = 1'b0;
        q = 'x;
        if (bus.mem_ready_out) begin
            @(posedge clk_in);
            #1;
        end
        bus.mem_valid_in = 1'b1;
        bus.mem_instr_in = 1'b0;
        bus.mem_addr_in  = a;
        bus.mem_wdata_in = d;
        bus.mem_wstrb_in = s;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.mem_ready_out) begin
                got = 1'b1;
                q   = bus.mem_rdata_out;
            end
        end
        bus.mem_valid_in = 1'b0;
        bus.mem_wstrb_in = 4'd0;
        if (!got) check($sformatf("ack timeout @%h", a), 64'd0, 64'd1);
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d,
                      input logic [3:0] s = 4'hF);
        logic [31:0] q;
        bus_xfer(reg_addr(ch, r), d, s, q);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] q);
        bus_xfer(reg_addr(ch, r), 32'd0, 4'd0, q);
    endtask

    task automatic trace(input int ch, input int n, output logic [63:0] t);
        t    = '0;
        t[0] = step_out[ch];
        for (int i = 1; i < n; i++) begin
            @(posedge clk_in);
            #1;
            t[i] = step_out[ch];
        end
    endtask

    // Holds a request for several cycles and reports whether any ack or data appeared.
    task automatic probe_no_ack(input string tag, input logic [31:0] a, input logic instr);
        logic seen = 1'b0;
        logic [31:0] data_or = '0;
        bus.mem_valid_in = 1'b1;
        bus.mem_instr_in = instr;
        bus.mem_addr_in  = a;
        bus.mem_wstrb_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            seen    = seen | bus.mem_ready_out;
            data_or = data_or | bus.mem_rdata_out;
        end
        bus.mem_valid_in = 1'b0;
        bus.mem_instr_in = 1'b0;
        check(tag, {31'd0, seen, data_or}, 64'd0);
    endtask

    logic [31:0] q;
    logic [63:0] t;
    logic [3:0]  pat;
    int          c_start;

    initial begin
        bus.mem_valid_in = 1'b0;
        bus.mem_instr_in = 1'b0;
        bus.mem_addr_in  = '0;
        bus.mem_wdata_in = '0;
        bus.mem_wstrb_in = '0;
        reset_n_in       = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset enable_n", 64'(enable_n_out), 64'hF);
        check("reset step", 64'(step_out), 64'h0);
        check("reset dir", 64'(dir_out), 64'h0);
        check("reset ready/rdata", {31'd0, bus.mem_ready_out, bus.mem_rdata_out}, 64'd0);
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                rd(c, r, q);
                check($sformatf("reset read ch%0d r%0d", c, r), 64'(q), 64'd0);
            end

        // Ch0: DIV=10, STEPS=3, DIR=1, EN=1, START.
        wr(0, 2, 32'd10);
        wr(0, 1, 32'd3);
        wr(0, 0, 32'h7);
        trace(0, 35, t);
        check("ch0 pulse train", t, 64'h01E0_781E);
        rd(0, 3, q);
        check("ch0 status done", 64'(q), 64'h2);
        rd(0, 1, q);
        check("ch0 steps left", 64'(q), 64'h0);
        rd(0, 0, q);
        check("ch0 ctrl readback", 64'(q), 64'h6);
        check("ch0 dir_out", 64'(dir_out[0]), 64'd1);
        check("ch0 enable_n", 64'(enable_n_out[0]), 64'd0);

        // Ch1: DIV=2 clamps to 8.
        wr(1, 2, 32'd2);
        wr(1, 1, 32'd2);
        wr(1, 0, 32'h5);
        trace(1, 22, t);
        check("ch1 clamped train", t, 64'h1E1E);
        rd(1, 3, q);
        check("ch1 status", 64'(q), 64'h2);

        // Ch2: long burst, STEPS write ignored, ABORT in the sixth pulse.
        wr(2, 2, 32'd10);
        wr(2, 1, 32'd100);
        wr(2, 0, 32'h5);
        c_start = cyc;
        wr(2, 1, 32'd7);
        for (int i = 0; i < 200 && cyc < c_start + 51; i++) @(posedge clk_in);
        #1;
        check("ch2 sixth pulse high", 64'(step_out[2]), 64'd1);
        wr(2, 0, 32'h9);
        check("ch2 abort drops step", 64'(step_out[2]), 64'd0);
        trace(2, 12, t);
        check("ch2 quiet after abort", t, 64'd0);
        rd(2, 1, q);
        check("ch2 steps remaining", 64'(q), 64'd95);
        rd(2, 3, q);
        check("ch2 status after abort", 64'(q), 64'h0);

        // Ch3: START with STEPS=0, then byte-lane write to DIV.
        wr(3, 0, 32'h1);
        trace(3, 12, t);
        check("ch3 no pulse", t, 64'd0);
        rd(3, 3, q);
        check("ch3 done", 64'(q), 64'h2);
        wr(3, 2, 32'h0000_1234);
        wr(3, 2, 32'h5566_77AB, 4'b0001);
        rd(3, 2, q);
        check("ch3 div byte0", 64'(q), 64'h12AB);

        // Decode and handshake.
        probe_no_ack("below range", 32'h1000_003C, 1'b0);
        probe_no_ack("above range", 32'h1000_0080, 1'b0);
        probe_no_ack("instr fetch", reg_addr(3, 2), 1'b1);
        bus.mem_valid_in = 1'b1;
        bus.mem_addr_in  = reg_addr(3, 2);
        bus.mem_wstrb_in = 4'd0;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            pat = {pat[2:0], bus.mem_ready_out};
        end
        bus.mem_valid_in = 1'b0;
        check("held valid ready gaps", 64'(pat), 64'hA);

        // Ch0 again: 5 steps with DIR=0; DIR change mid-run stays frozen.
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h5);
        check("ch0 dir latched 0", 64'(dir_out[0]), 64'd0);
        wr(0, 0, 32'h6);
        check("ch0 dir frozen", 64'(dir_out[0]), 64'd0);
        q = 32'h1;
        for (int i = 0; i < 100 && q[0]; i++) rd(0, 3, q);
`ifdef STEP_POSITION_EN
        check("ch0 position status", 64'(q), 64'hFFFF_FE02);
`else
        check("ch0 status no position", 64'(q), 64'h2);
`endif
        check("ch0 dir follows in idle", 64'(dir_out[0]), 64'd1);

        // Reset mid-pulse on ch1.
        wr(1, 1, 32'd4);
        wr(1, 0, 32'h5);
        repeat (2) @(posedge clk_in);
        #1;
        check("ch1 pulse before reset", 64'(step_out[1]), 64'd1);
        #2 reset_n_in = 1'b0;
        #1;
        check("async reset step", 64'(step_out), 64'd0);
        check("async reset enable_n", 64'(enable_n_out), 64'hF);
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        rd(1, 1, q);
        check("steps cleared by reset", 64'(q), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
